serial_subtractor: RTL and testbench

//   Bit-serial N-bit subtractor built around a single full-subtractor cell plus
//   a borrow flip-flop. Computes diff = a - b - bin, LSB first, one bit per clock.

---
 rtl/serial_subtractor.sv | 175 +++++++++++++++++
 tb/tb_serial_subtractor.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell plus a borrow flop, diff = a - b - bin, LSB first.
// Latency: start accepted at edge 0 -> done pulse (with diff/bout/ovf valid) during cycle WIDTH+1.
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped (not queued).
//
// Ports: clk, rst_n (synchronous, active-low), start, a/b/bin (captured on accepted start),
//        busy (SHIFT or DONE), done (one-cycle pulse), diff/bout/ovf (held until next done).
// Optional feature macro: SERIAL_SUB_OVF_EN -- when defined, ovf is a two's-complement
//        overflow flag; when undefined, ovf is tied to 0 and no MSB capture flops exist.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  // Full-subtractor cell operating on the current LSBs.
  logic             d_bit;
  logic             br_nxt;
  logic [WIDTH-1:0] res_shift;
  logic             last_bit;

  always_comb begin
    d_bit     = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
    br_nxt    = (~a_sr_q[0] & b_sr_q[0]) | (~a_sr_q[0] & br_q) | (b_sr_q[0] & br_q);
    res_shift = {d_bit, res_sr_q[WIDTH-1:1]};
    last_bit  = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end

      S_SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = res_shift;
        br_d     = br_nxt;
        cnt_d    = cnt_q + 1'b1;
        if (last_bit) begin
          // Outputs are registered, so the result is loaded on the edge that
          // enters DONE; done and diff/bout/ovf are then all visible during DONE.
          cnt_d   = '0;
          state_d = S_DONE;
          done_d  = 1'b1;
          diff_d  = res_shift;
          bout_d  = br_nxt;
`ifdef SERIAL_SUB_OVF_EN
          // d_bit on the last step is the result MSB.
          ovf_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
`endif
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`else
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=8): directed cases plus random operations against an arithmetic model.
// Latency: checks done arrives in cycle WIDTH+1 after the accepting edge.
// Backpressure: exercises start-while-busy (dropped) and reset mid-operation (aborted).
module tb_serial_subtractor;

  localparam int WIDTH = 8;
`ifdef SERIAL_SUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  int n_chk;
  int n_fail;
  int done_cnt;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every done pulse seen, sampled away from the active edge.
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic ci,
                       output logic [WIDTH-1:0] ed, output logic eb, output logic eo);
    int ua, ub, r, sa, sb, sr;
    ua = int'(av);
    ub = int'(bv);
    r  = ua - ub - int'(ci);
    ed = r[WIDTH-1:0];
    eb = (ua < ub + int'(ci));
    sa = int'($signed(av));
    sb = int'($signed(bv));
    sr = sa - sb - int'(ci);
    eo = OVF_EN && ((sr > (2**(WIDTH-1)) - 1) || (sr < -(2**(WIDTH-1))));
  endtask

  // Issues one operation from IDLE (called at a negedge) and checks it end to end.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic ci,
                        input string tag);
    logic [WIDTH-1:0] ed;
    logic eb, eo;
    int cyc, d0;
    model(av, bv, ci, ed, eb, eo);
    d0 = done_cnt;
    start = 1'b1; a = av; b = bv; bin = ci;
    @(negedge clk);
    // Scramble inputs to show operands were captured at start.
    start = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
    cyc = 1;
    chk({tag, " busy_shift"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(WIDTH + 1));
    chk({tag, " diff"}, 32'(diff), 32'(ed));
    chk({tag, " bout"}, 32'(bout), 32'(eb));
    chk({tag, " ovf"}, 32'(ovf), 32'(eo));
    chk({tag, " busy_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
    chk({tag, " idle"}, 32'(busy), 32'd0);
    chk({tag, " hold"}, 32'(diff), 32'(ed));
    chk({tag, " ndone"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0, cyc;
    n_chk = 0; n_fail = 0; done_cnt = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;

    // 1. Reset state
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst diff", 32'(diff), 32'd0);
    chk("rst bout", 32'(bout), 32'd0);
    chk("rst ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 2-4. Directed arithmetic cases, anchored with literal expectations too
    run_op(8'd100, 8'd37, 1'b0, "basic");
    chk("basic lit", 32'({bout, ovf, diff}), 32'({1'b0, 1'b0, 8'd63}));
    run_op(8'd5, 8'd9, 1'b0, "uflow");
    chk("uflow lit", 32'({bout, diff}), 32'({1'b1, 8'hFC}));
    run_op(8'd0, 8'd0, 1'b1, "bin_only");
    chk("bin_only lit", 32'({bout, diff}), 32'({1'b1, 8'hFF}));
    run_op(8'h80, 8'h01, 1'b0, "sovf");
    chk("sovf lit", 32'({ovf, bout, diff}), 32'({OVF_EN, 1'b0, 8'h7F}));
    run_op(8'hFF, 8'hFF, 1'b1, "ff_ff_bin");
    run_op(8'h7F, 8'hFF, 1'b0, "pos_minus_neg");

    // 5. Start while busy is ignored
    d0 = done_cnt;
    start = 1'b1; a = 8'd200; b = 8'd50; bin = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1; a = 8'd1; b = 8'd1;
    @(negedge clk); start = 1'b0;
    cyc = 4;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("busy_start latency", 32'(cyc), 32'(WIDTH + 1));
    chk("busy_start diff", 32'(diff), 32'd150);
    chk("busy_start bout", 32'(bout), 32'd0);
    repeat (WIDTH + 4) @(negedge clk);
    chk("busy_start ndone", 32'(done_cnt - d0), 32'd1);
    chk("busy_start hold", 32'(diff), 32'd150);

    // 6. Reset mid-operation
    d0 = done_cnt;
    start = 1'b1; a = 8'd7; b = 8'd3; bin = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst diff", 32'(diff), 32'd0);
    chk("midrst bout_ovf_done", 32'({bout, ovf, done}), 32'd0);
    rst_n = 1'b1;
    repeat (WIDTH + 4) @(negedge clk);
    chk("midrst ndone", 32'(done_cnt - d0), 32'd0);
    chk("midrst idle", 32'(busy), 32'd0);
    run_op(8'd7, 8'd3, 1'b0, "after_rst");
    chk("after_rst lit", 32'({bout, diff}), 32'({1'b0, 8'd4}));

    // Random operations, with occasional idle gaps
    for (int i = 0; i < 40; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
